// File: rtl/gray_count_event_tx.sv
// Gray counter event transmitter: sync, decode, classify and queue
// counter steps, then hand them out over a dav_/rfd 4-phase handshake.
module gray_count_event_tx #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic [2:0] gray,
  input  logic       rfd,
  output logic       dav_,
  output logic [4:0] data,
  output logic       ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] WAIT_RFD = 2'd2;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    prev;
  logic [2:0]    bin;
  logic [1:0]    code;
  logic          change;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;

  logic [1:0]    state;

  // Decode synchronised Gray to binary and classify against prev
  always_comb begin
    bin    = '0;
    code   = 2'b11;
    bin[2] = sync2[2];
    bin[1] = sync2[2] ^ sync2[1];
    bin[0] = bin[1] ^ sync2[0];
    change = (bin != prev);
    if (bin == prev + 3'd1) begin
      code = 2'b01;
    end else if (bin == prev - 3'd1) begin
      code = 2'b10;
    end else begin
      code = 2'b11;
    end
  end

  // FIFO status and pop/write qualification
  always_comb begin
    full  = (count == DEPTH_C);
    empty = (count == '0);
    pop   = (state == WAIT_ACK) && !rfd;
    wr_en = change && (!full || pop);
  end

  // Two-flop synchroniser and last-accepted value
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= gray;
      sync2 <= sync1;
      prev  <= bin;
    end
  end

  // FIFO storage; contents are don't-care while not counted
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wptr] <= {code, bin};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (change && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Output handshake FSM
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      dav_  <= 1'b1;
      data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty && rfd) begin
            data  <= mem[rptr];
            dav_  <= 1'b0;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!rfd) begin
            dav_  <= 1'b1;
            state <= WAIT_RFD;
          end
        end
        WAIT_RFD: begin
          if (rfd) begin
            state <= IDLE;
          end
        end
        default: begin
          dav_  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_count_event_tx.sv
// Bench for gray_count_event_tx: scoreboard of expected events,
// consumer side of the dav_/rfd handshake.
module tb_gray_count_event_tx;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset_;
  logic [2:0] gray;
  logic       rfd;
  logic       dav_;
  logic [4:0] data;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  logic [4:0] q [$];
  logic [2:0] mprev;
  logic       exp_ovf;

  gray_count_event_tx #(.DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .gray   (gray),
    .rfd    (rfd),
    .dav_   (dav_),
    .data   (data),
    .ovf    (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] g2b(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  // drive a new gray value and record the event the DUT should produce
  task automatic step(input logic [2:0] g);
    logic [2:0] b;
    logic [2:0] up;
    logic [2:0] dn;
    logic [1:0] c;
    @(negedge clock);
    gray = g;
    b  = g2b(g);
    up = mprev + 3'd1;
    dn = mprev - 3'd1;
    if (b != mprev) begin
      if (b == up)      c = 2'b01;
      else if (b == dn) c = 2'b10;
      else              c = 2'b11;
      if (q.size() < DEPTH) q.push_back({c, b});
      else exp_ovf = 1'b1;
      mprev = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_  = 1'b0;
    gray    = 3'b000;
    rfd     = 1'b1;
    q.delete();
    mprev   = 3'b000;
    exp_ovf = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // consume one event and compare it with the scoreboard head
  task automatic recv(input string name);
    logic       got;
    logic [4:0] exp;
    logic [4:0] held;
    rfd = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dav_ === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: dav_=%b required 0", name, dav_);
      return;
    end
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected event data=%b", name, data);
    end else begin
      exp = q.pop_front();
      if (data !== exp) begin
        bad++;
        $display("FAIL %s data=%b required %b", name, data, exp);
      end
    end
    held = data;
    @(negedge clock);
    total++;
    if (dav_ !== 1'b0 || data !== held) begin
      bad++;
      $display("FAIL %s hold dav_=%b data=%b required 0 %b",
               name, dav_, data, held);
    end
    rfd = 1'b0;
    @(negedge clock);
    total++;
    if (dav_ !== 1'b1) begin
      bad++;
      $display("FAIL %s release dav_=%b required 1", name, dav_);
    end
  endtask

  // confirm nothing is offered for n cycles with rfd high
  task automatic quiet(input string name, input int n);
    int lows;
    rfd  = 1'b1;
    lows = 0;
    repeat (n) begin
      @(negedge clock);
      if (dav_ !== 1'b1) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL %s dav_ low for %0d cycles required 0", name, lows);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dav_ !== 1'b1) begin
      bad++;
      $display("FAIL reset_dav dav_=%b required 1", dav_);
    end
    total++;
    if (data !== 5'b00000) begin
      bad++;
      $display("FAIL reset_data data=%b required 00000", data);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf ovf=%b required 0", ovf);
    end
    quiet("reset_idle", 10);
  endtask

  task automatic test_up_latency();
    int n;
    do_reset();
    step(3'b001);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (dav_ === 1'b0) begin
        n = i;
        break;
      end
    end
    total++;
    if (n < 3 || n > 4) begin
      bad++;
      $display("FAIL latency edges=%0d required 3..4", n);
    end
    recv("up_001");
  endtask

  task automatic test_wrap();
    do_reset();
    step(3'b100);
    repeat (4) @(negedge clock);
    step(3'b000);
    repeat (4) @(negedge clock);
    recv("down_111");
    recv("up_000");
    quiet("wrap_none", 6);
  endtask

  task automatic test_jump();
    do_reset();
    step(3'b011);
    recv("jump_010");
  endtask

  task automatic test_overflow();
    logic [2:0] seq [5];
    do_reset();
    rfd = 1'b0;
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
    foreach (seq[i]) begin
      step(seq[i]);
      repeat (2) @(negedge clock);
    end
    repeat (4) @(negedge clock);
    total++;
    if (dav_ !== 1'b1) begin
      bad++;
      $display("FAIL ovf_wait dav_=%b required 1", dav_);
    end
    total++;
    if (ovf !== exp_ovf) begin
      bad++;
      $display("FAIL ovf_flag ovf=%b required %b", ovf, exp_ovf);
    end
    for (int i = 0; i < DEPTH; i++) recv($sformatf("ovf_ev%0d", i));
    quiet("ovf_lost", 10);
    total++;
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky ovf=%b required 1", ovf);
    end
  endtask

  task automatic test_mid_reset();
    logic got;
    do_reset();
    step(3'b001);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dav_ === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL midrst_setup dav_=%b required 0", dav_);
    end
    step(3'b011);
    repeat (4) @(negedge clock);
    #2;
    reset_ = 1'b0;
    gray   = 3'b000;
    #1;
    total++;
    if (dav_ !== 1'b1) begin
      bad++;
      $display("FAIL midrst_dav dav_=%b required 1", dav_);
    end
    q.delete();
    mprev   = 3'b000;
    exp_ovf = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    quiet("midrst_stale", 12);
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ovf ovf=%b required 0", ovf);
    end
  endtask

  initial begin
    reset_  = 1'b0;
    gray    = 3'b000;
    rfd     = 1'b1;
    mprev   = 3'b000;
    exp_ovf = 1'b0;
    test_reset();
    test_up_latency();
    test_wrap();
    test_jump();
    test_overflow();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
